// File: rtl/pipe_stage_ctrl.sv
// PC holder and ID/EX/MEM/WB pipeline registers driven by hazard-unit pause/bubble controls.
// Optional PIPE_PERF_EN adds stall, bubble and retire counters.
module pipe_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned CTRL_W   = 24,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_pause,
  input  logic [3:0]        pause,
  input  logic [3:0]        bubble,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [CTRL_W-1:0] ex_in_ctrl,
  input  logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] wb_in_data,
`ifdef PIPE_PERF_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles,
  output logic [31:0]       retired,
`endif
  output logic [31:0]       pc,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       ex_pc,
  output logic [31:0]       mem_pc,
  output logic [31:0]       wb_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] wb_data
);

  // Stage bits: 3 = ID, 2 = EX, 1 = MEM, 0 = WB; bubble outranks pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      id_pc     <= '0;
      ex_pc     <= '0;
      mem_pc    <= '0;
      wb_pc     <= '0;
      id_inst   <= '0;
      ex_ctrl   <= '0;
      mem_data  <= '0;
      wb_data   <= '0;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc;
      else if (!pc_pause && if_valid)
        pc <= pc + 32'd4;

      if (bubble[3]) begin
        id_valid <= 1'b0;
      end else if (!pause[3]) begin
        id_valid <= if_valid & ~redirect_valid;
        id_pc    <= pc;
        id_inst  <= if_inst;
      end

      if (bubble[2]) begin
        ex_valid <= 1'b0;
      end else if (!pause[2]) begin
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_ctrl  <= ex_in_ctrl;
      end

      if (bubble[1]) begin
        mem_valid <= 1'b0;
      end else if (!pause[1]) begin
        mem_valid <= ex_valid;
        mem_pc    <= ex_pc;
        mem_data  <= mem_in_data;
      end

      if (bubble[0]) begin
        wb_valid <= 1'b0;
      end else if (!pause[0]) begin
        wb_valid <= mem_valid;
        wb_pc    <= mem_pc;
        wb_data  <= wb_in_data;
      end
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
      retired       <= '0;
    end else begin
      if (pc_pause && !redirect_valid)
        stall_cycles <= stall_cycles + 32'd1;
      if (|bubble)
        bubble_cycles <= bubble_cycles + 32'd1;
      if (wb_valid)
        retired <= retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed hazard scenarios plus randomized traffic
// compared against an array-based pipeline model.
module tb_pipe_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_pause;
  logic [3:0]  pause, bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [23:0] ex_in_ctrl;
  logic [31:0] mem_in_data, wb_in_data;
  logic [31:0] pc;
  logic        id_valid, ex_valid, mem_valid, wb_valid;
  logic [31:0] id_pc, ex_pc, mem_pc, wb_pc;
  logic [31:0] id_inst;
  logic [23:0] ex_ctrl;
  logic [31:0] mem_data, wb_data;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles, retired;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.RESET_PC(32'h0), .INST_W(32), .CTRL_W(24), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_pause(pc_pause), .pause(pause), .bubble(bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_inst(if_inst), .ex_in_ctrl(ex_in_ctrl), .mem_in_data(mem_in_data), .wb_in_data(wb_in_data),
`ifdef PIPE_PERF_EN
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles), .retired(retired),
`endif
    .pc(pc), .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc), .wb_pc(wb_pc),
    .id_inst(id_inst), .ex_ctrl(ex_ctrl), .mem_data(mem_data), .wb_data(wb_data)
  );

  // Reference model: index 0..3 = ID, EX, MEM, WB
  logic [31:0] m_pc;
  logic        m_valid [4];
  logic [31:0] m_spc   [4];
  logic [31:0] m_pay   [4];
  int unsigned m_stall, m_bub, m_ret;

  function automatic logic [31:0] d_spc(int s);
    case (s) 0: return id_pc; 1: return ex_pc; 2: return mem_pc; default: return wb_pc; endcase
  endfunction
  function automatic logic d_valid(int s);
    case (s) 0: return id_valid; 1: return ex_valid; 2: return mem_valid; default: return wb_valid; endcase
  endfunction
  function automatic logic [31:0] d_pay(int s);
    case (s) 0: return id_inst; 1: return {8'h0, ex_ctrl}; 2: return mem_data; default: return wb_data; endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc"}, pc, m_pc);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s:valid%0d", tag, s), {31'h0, d_valid(s)}, {31'h0, m_valid[s]});
      // PC and payload are only meaningful while the stage holds a valid instruction
      if (m_valid[s]) begin
        chk($sformatf("%s:spc%0d", tag, s), d_spc(s), m_spc[s]);
        chk($sformatf("%s:pay%0d", tag, s), d_pay(s), m_pay[s]);
      end
    end
`ifdef PIPE_PERF_EN
    chk({tag, ":stall"}, stall_cycles, m_stall);
    chk({tag, ":bubcnt"}, bubble_cycles, m_bub);
    chk({tag, ":retired"}, retired, m_ret);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0; m_spc[s] = '0; m_pay[s] = '0;
    end
    m_stall = 0; m_bub = 0; m_ret = 0;
  endtask

  task automatic tick(input string tag);
    logic        nv [4];
    logic [31:0] np [4];
    logic [31:0] nd [4];
    logic        sv;
    logic [31:0] sp, sd;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        sv = if_valid && !redirect_valid; sp = m_pc; sd = if_inst;
      end else begin
        sv = m_valid[s-1]; sp = m_spc[s-1];
        sd = (s == 1) ? {8'h0, ex_in_ctrl} : (s == 2) ? mem_in_data : wb_in_data;
      end
      nv[s] = m_valid[s]; np[s] = m_spc[s]; nd[s] = m_pay[s];
      if (bubble[3-s]) nv[s] = 1'b0;
      else if (!pause[3-s]) begin nv[s] = sv; np[s] = sp; nd[s] = sd; end
    end
    if (pc_pause && !redirect_valid) m_stall++;
    if (bubble != 4'b0) m_bub++;
    if (m_valid[3]) m_ret++;
    if (redirect_valid) m_pc = redirect_pc;
    else if (!pc_pause && if_valid) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = nv[s]; m_spc[s] = np[s]; m_pay[s] = nd[s];
    end
    check_all(tag);
  endtask

  task automatic quiet();
    pc_pause = 1'b0; pause = 4'b0; bubble = 4'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    if_valid = 1'b1; if_inst = 32'h0000_0013;
    ex_in_ctrl = 24'h0; mem_in_data = 32'h0; wb_in_data = 32'h0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    #2 rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    pc_pause       = ($urandom_range(3) == 0);
    pause          = {($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
    bubble         = {($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0)};
    redirect_valid = ($urandom_range(9) == 0);
    redirect_pc    = $urandom() & 32'hFFFF_FFFC;
    if_valid       = ($urandom_range(3) != 0);
    if_inst        = $urandom();
    ex_in_ctrl     = 24'($urandom());
    mem_in_data    = $urandom();
    wb_in_data     = $urandom();
  endtask

  initial begin
    quiet();
    rst_n = 1'b1;
    #2;
    do_reset("reset");
    chk("reset_pc", pc, 32'h0);
    chk("reset_idv", {31'h0, id_valid}, 32'h0);

    // Free-running fill
    for (int k = 1; k <= 5; k++) begin
      if_inst = 32'h0000_0013; ex_in_ctrl = 24'(k * 3); mem_in_data = 32'(k * 5); wb_in_data = 32'(k * 7);
      tick($sformatf("fill%0d", k));
      chk($sformatf("fill_pc%0d", k), pc, 32'(4 * k));
      if (k == 1) chk("fill_idv1", {31'h0, id_valid}, 32'h1);
      if (k == 4) begin
        chk("fill_wbv4", {31'h0, wb_valid}, 32'h1);
        chk("fill_wbpc4", wb_pc, 32'h0);
      end
    end

    // Load-use: ID holds at 0x10, EX squashed, MEM/WB advance
    pc_pause = 1'b1; pause = 4'b1000; bubble = 4'b0100;
    tick("loaduse");
    chk("lu_id_pc", id_pc, 32'h10);
    chk("lu_ex_v", {31'h0, ex_valid}, 32'h0);
    chk("lu_mem_pc", mem_pc, 32'h0C);
    chk("lu_pc", pc, 32'h14);
    quiet();
    tick("lu_next");
    chk("lu_ex_pc", ex_pc, 32'h10);
    chk("lu_ex_v2", {31'h0, ex_valid}, 32'h1);

    // Jump
    redirect_valid = 1'b1; redirect_pc = 32'h200; bubble = 4'b1100; pc_pause = 1'b1;
    tick("jump");
    chk("jmp_pc", pc, 32'h200);
    chk("jmp_idv", {31'h0, id_valid}, 32'h0);
    chk("jmp_exv", {31'h0, ex_valid}, 32'h0);
    chk("jmp_memv", {31'h0, mem_valid}, 32'h1);
    chk("jmp_mempc", mem_pc, 32'h10);

    // Exception
    redirect_pc = 32'h80; bubble = 4'b1110;
    tick("exc");
    chk("exc_pc", pc, 32'h80);
    chk("exc_memv", {31'h0, mem_valid}, 32'h0);
    chk("exc_wbv", {31'h0, wb_valid}, 32'h1);
    chk("exc_wbpc", wb_pc, 32'h10);

    // Bubble beats pause on MEM
    quiet();
    for (int k = 0; k < 3; k++) tick("refill");
    pause = 4'b0010; bubble = 4'b0010;
    tick("prio");
    chk("prio_memv", {31'h0, mem_valid}, 32'h0);

    // PC wrap and fetch-invalid hold
    quiet();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick("wrap_set");
    redirect_valid = 1'b0;
    tick("wrap");
    chk("wrap_pc", pc, 32'h0);
    if_valid = 1'b0;
    tick("ifinv");
    chk("ifinv_pc", pc, 32'h0);
    chk("ifinv_idv", {31'h0, id_valid}, 32'h0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      tick("rand");
      if (k == 200) begin
        quiet();
        #2;
        do_reset("rand_rst");
      end
    end

`ifdef PIPE_PERF_EN
    quiet();
    #2;
    do_reset("perf_rst");
    for (int c = 0; c < 10; c++) begin
      quiet();
      if (c >= 2 && c <= 4) pc_pause = 1'b1;
      if (c == 6 || c == 8) bubble = 4'b0001;
      tick("perf");
    end
    chk("perf_stall", stall_cycles, 32'd3);
    chk("perf_bub", bubble_cycles, 32'd2);
    chk("perf_ret", retired, 32'(m_ret));
    quiet();
    tick("perf_more");
    #2 rst_n = 1'b0;
    #1;
    chk("perf_clr_stall", stall_cycles, 32'h0);
    chk("perf_clr_bub", bubble_cycles, 32'h0);
    chk("perf_clr_ret", retired, 32'h0);
    #5 rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
